// File: rtl/pb_pkg.sv
// Shared types and defaults for push-button conditioning.
// Default cycle counts assume the 50 MHz GL0 fabric clock.
package pb_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } pb_state_t;

    // 10 ms debounce, 1 s long press at 50 MHz
    localparam int unsigned PB_DEBOUNCE_DEF   = 500000;
    localparam int unsigned PB_LONG_PRESS_DEF = 50000000;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pad input.
// Both flops load RST_VAL so the output is quiet out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/pb_event_gen.sv
// Push-button debouncer producing press, release and long-press strobes,
// a debounced level and a wrapping press counter.
module pb_event_gen
    import pb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = PB_DEBOUNCE_DEF,
    parameter int unsigned LONG_PRESS_CYCLES = PB_LONG_PRESS_DEF,
    parameter bit          ACTIVE_LOW        = 1'b1,
    parameter int unsigned COUNT_W           = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PB_SW,
    output logic               PB_LEVEL,
    output logic               PRESS,
    output logic               RELEASE,
    output logic               LONG_PRESS,
    output logic [COUNT_W-1:0] PRESS_COUNT
);

    localparam int unsigned DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int unsigned HW = cnt_w(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX = HW'(LONG_PRESS_CYCLES - 1);

    logic s2;
    logic p;

    pb_state_t state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [HW-1:0] hcnt_inc;
    logic hold_max;
    logic releasing;
    logic flag_q, flag_d;
    logic level_q, level_d;
    logic press_q, press_d;
    logic rel_q, rel_d;
    logic lp_q, lp_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (PB_SW),
        .q   (s2)
    );

    assign p = s2 ^ ACTIVE_LOW;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RELEASED;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            flag_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            lp_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            flag_q  <= flag_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            lp_q    <= lp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hold_max  = (hcnt_q == H_MAX);
    assign hcnt_inc  = hold_max ? hcnt_q : hcnt_q + 1'b1;
    assign releasing = !p && (dcnt_q == D_MAX);

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        flag_d  = flag_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        lp_d    = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            RELEASED: begin
                if (p) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!p) begin
                    state_d = RELEASED;
                end else if (dcnt_q == D_MAX) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    hcnt_d  = '0;
                    flag_d  = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            PRESSED: begin
                hcnt_d = hcnt_inc;
                if (hold_max && !flag_q) begin
                    lp_d   = 1'b1;
                    flag_d = 1'b1;
                end
                if (!p) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end
            end
            RELEASE_WAIT: begin
                hcnt_d = hcnt_inc;
                // An accepted release wins over a long press on the same edge
                if (hold_max && !flag_q && !releasing) begin
                    lp_d   = 1'b1;
                    flag_d = 1'b1;
                end
                if (p) begin
                    state_d = PRESSED;
                end else if (releasing) begin
                    state_d = RELEASED;
                    rel_d   = 1'b1;
                    level_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    assign PB_LEVEL    = level_q;
    assign PRESS       = press_q;
    assign RELEASE     = rel_q;
    assign LONG_PRESS  = lp_q;
    assign PRESS_COUNT = cnt_q;

endmodule
